regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised multi-read-port integer register file with a per-register pending-write scoreboard, for the pipelined core's decode/writeback boundary. Decode reads any number of source operands and marks destination registers busy at issue. Writeback writes results and clears busy. Same-cycle writeback data is bypassed to readers. Register 0 is hardwired to zero and is never busy.

## Interface
- ADDR_WIDTH, 5, register index width; depth is 2^ADDR_WIDTH
- DATA_WIDTH, 32, register data width
- NREAD, 2, number of read ports (1..4)

- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset; asynchronous, active-low
- raddr  input  NREAD*ADDR_WIDTH  read indices; port k is bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- rdata  output  NREAD*DATA_WIDTH  read data, packed the same way as raddr
- rbusy  output  NREAD  port k's source register has a pending write not satisfied this cycle
- issue_en  input  1  mark issue_rd busy at the next edge
- issue_rd  input  ADDR_WIDTH  destination register of the issued instruction
- wen  input  1  writeback valid
- waddr  input  ADDR_WIDTH  writeback index
- wdata  input  DATA_WIDTH  writeback data
- flush  input  1  clear every busy bit at the next edge; register contents unaffected
- any_busy  output  1  OR of all busy bits (registered state, no bypass)

## Operation
- Storage: 2^ADDR_WIDTH × DATA_WIDTH array plus a 2^ADDR_WIDTH busy vector.
- Reset (rst_n low, asynchronous): every register is 0 and every busy bit is 0. Outputs follow combinationally: rdata all 0, rbusy all 0, any_busy 0.
- Write: wen=1 and waddr≠0 → rf[waddr] ← wdata at the edge. waddr=0 → ignored.
- Read, per port k, combinational:
  - raddr_k=0 → rdata_k=0 and rbusy_k=0.
  - wen=1 and waddr=raddr_k≠0 → rdata_k=wdata (bypass).
  - Otherwise rdata_k=rf[raddr_k].
- rbusy_k = busy[raddr_k] & ~(wen & waddr==raddr_k). A same-cycle writeback satisfies the reader.
- Busy update at the edge, in priority order:
  1. flush=1 → all busy bits 0. Simultaneous issue_en is discarded. Simultaneous wen still writes data.
  2. issue_en=1, issue_rd≠0 → busy[issue_rd]=1. This wins over a same-cycle writeback to the same index, because the new instruction's write is still pending.
  3. wen=1, waddr≠0, not set by rule 2 → busy[waddr]=0.
- issue_rd=0 → no effect. busy[0] is constant 0.
- Writeback to a non-busy register is legal: data is written and busy stays 0.
- Only one outstanding write per register is tracked. Decode must not re-issue to a busy rd; doing so is undefined for the scoreboard but never corrupts data.

## Timing
- Read latency is 0 cycles (combinational from raddr, wen, waddr, wdata and state).
- A write is visible through the array one cycle after the edge, and through the bypass in the same cycle.
- Issue → rbusy visible in the cycle after the issue edge.
- Writeback → rbusy drops in the same cycle via the bypass term, and busy state clears at the edge.
- Reset asserted mid-operation clears state immediately, without waiting for an edge. The first edge after rst_n rises performs normal updates.

## Configuration
- REGFILE_TRACE_EN defined: a simulation-only always block shadows the array. On each accepted write that changes a value it prints "x<i> changed, from 0x<old>(<signed old>) to 0x<new>(<signed new>)". On each issue it prints "x<i> busy". On a flush it prints "scoreboard flush". The block is excluded from synthesis.
- REGFILE_TRACE_EN undefined: no shadow storage and no $display statements. Functional behaviour is identical.

## Test plan
- Reset with rst_n low mid-run, after writing x5=0x1234 and issuing x6 → rdata on every port is 0, rbusy=0, any_busy=0 immediately, before any clock edge.
- Write x3=0xDEADBEEF, then next cycle raddr0=3, raddr1=0 → rdata0=0xDEADBEEF, rdata1=0. Write x0=0xFFFF → x0 still reads 0.
- Issue x7, then hold raddr0=7 for 2 cycles → rbusy0=1. Cycle 3: wen x7=0x55 → same cycle rdata0=0x55 and rbusy0=0. Next cycle busy cleared and rdata0=0x55 from the array.
- Same cycle: issue_rd=9, wen waddr=9 wdata=0xA → x9=0xA written, busy[9]=1 after the edge, rbusy for x9 =1 in the following cycle.
- Issue x1, x2, x4 on successive cycles, then flush with issue_en=1 issue_rd=8 and wen x2=0x77 → all busy 0, any_busy=0, x8 not busy, x2=0x77.
- NREAD=4, ADDR_WIDTH=4, DATA_WIDTH=16: all four ports read x15 while wen x15=0xBEEF → all rdata=0xBEEF. issue_rd=0 → any_busy stays 0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-read-port integer register file with a
// per-register pending-write (busy) scoreboard for the decode/writeback
// boundary. Register 0 reads as zero and is never busy. Writeback data is
// bypassed to readers in the same cycle.
//
// Optional build macro: REGFILE_TRACE_EN
//   defined   -> a simulation-only shadow of the array prints a trace line
//                for every value-changing write, every issue and every flush
//   undefined -> no shadow storage and no trace output
module regfile_scoreboard #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NREAD      = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREAD*ADDR_WIDTH-1:0] raddr,
  output logic [NREAD*DATA_WIDTH-1:0] rdata,
  output logic [NREAD-1:0]            rbusy,
  input  logic                        issue_en,
  input  logic [ADDR_WIDTH-1:0]       issue_rd,
  input  logic                        wen,
  input  logic [ADDR_WIDTH-1:0]       waddr,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic                        flush,
  output logic                        any_busy
);

  localparam int DEPTH = 32'd1 << ADDR_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0] rf_r [DEPTH];
  logic [DEPTH-1:0]      busy_r;
  logic [DEPTH-1:0]      busy_next_s;
  logic                  any_busy_r;
  logic                  wr_accept_s;
  logic                  issue_accept_s;

  // A write or issue targeting register 0 has no effect anywhere.
  assign wr_accept_s    = wen && (waddr != ZERO_ADDR);
  assign issue_accept_s = issue_en && (issue_rd != ZERO_ADDR);

  // Register array: reset clears every entry, accepted writebacks update one.
  // Entry 0 is never written, so it stays zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf_r[i] <= ZERO_DATA;
      end
    end else if (wr_accept_s) begin
      rf_r[waddr] <= wdata;
    end
  end

  // Next busy vector: flush dominates; otherwise writeback clears and issue
  // sets, with issue applied last so a new pending write outranks a
  // same-cycle writeback to the same register.
  always_comb begin
    busy_next_s = busy_r;
    if (flush) begin
      busy_next_s = {DEPTH{1'b0}};
    end else begin
      if (wr_accept_s) begin
        busy_next_s[waddr] = 1'b0;
      end else begin
        busy_next_s = busy_next_s;
      end
      if (issue_accept_s) begin
        busy_next_s[issue_rd] = 1'b1;
      end else begin
        busy_next_s = busy_next_s;
      end
    end
    busy_next_s[0] = 1'b0;
  end

  // Busy state register and its registered OR summary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r     <= {DEPTH{1'b0}};
      any_busy_r <= 1'b0;
    end else begin
      busy_r     <= busy_next_s;
      any_busy_r <= |busy_next_s;
    end
  end

  assign any_busy = any_busy_r;

  // Read ports: zero register, writeback bypass, then array/scoreboard.
  for (genvar k = 0; k < NREAD; k++) begin : g_read
    logic [ADDR_WIDTH-1:0] ra_s;
    logic [DATA_WIDTH-1:0] rd_s;
    logic                  rb_s;

    assign ra_s = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];

    // Select this port's data and pending status for the current cycle.
    always_comb begin
      rd_s = ZERO_DATA;
      rb_s = 1'b0;
      if (ra_s == ZERO_ADDR) begin
        rd_s = ZERO_DATA;
        rb_s = 1'b0;
      end else if (wen && (waddr == ra_s)) begin
        rd_s = wdata;
        rb_s = 1'b0;
      end else begin
        rd_s = rf_r[ra_s];
        rb_s = busy_r[ra_s];
      end
    end

    assign rdata[k*DATA_WIDTH +: DATA_WIDTH] = rd_s;
    assign rbusy[k]                          = rb_s;
  end

`ifdef REGFILE_TRACE_EN
  logic [DATA_WIDTH-1:0] trace_shadow_r [DEPTH];

  // Simulation trace: mirror the array and report changes, issues, flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        trace_shadow_r[i] <= ZERO_DATA;
      end
    end else begin
      if (flush) begin
        $display("scoreboard flush");
      end else if (issue_accept_s) begin
        $display("x%0d busy", issue_rd);
      end
      if (wr_accept_s && (wdata != trace_shadow_r[waddr])) begin
        $display("x%0d changed, from 0x%h(%0d) to 0x%h(%0d)", waddr,
                 trace_shadow_r[waddr], $signed(trace_shadow_r[waddr]),
                 wdata, $signed(wdata));
        trace_shadow_r[waddr] <= wdata;
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus a
// randomized run checked against an array-based reference model. A second
// instance with 4 ports, 4-bit indices and 16-bit data covers the wide case.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst_n;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        flush;
  logic        any_busy;

  logic [15:0] w_raddr;
  logic [63:0] w_rdata;
  logic [3:0]  w_rbusy;
  logic        w_issue_en;
  logic [3:0]  w_issue_rd;
  logic        w_wen;
  logic [3:0]  w_waddr;
  logic [15:0] w_wdata;
  logic        w_flush;
  logic        w_any_busy;

  int nvec;
  int nerr;

  // reference model state
  logic [31:0] m_rf   [32];
  logic        m_busy [32];

  regfile_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .issue_en(issue_en), .issue_rd(issue_rd), .wen(wen), .waddr(waddr),
    .wdata(wdata), .flush(flush), .any_busy(any_busy)
  );

  regfile_scoreboard #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .NREAD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .raddr(w_raddr), .rdata(w_rdata), .rbusy(w_rbusy),
    .issue_en(w_issue_en), .issue_rd(w_issue_rd), .wen(w_wen), .waddr(w_waddr),
    .wdata(w_wdata), .flush(w_flush), .any_busy(w_any_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_rf[i]   = 32'd0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Apply the clock-edge effect of the currently driven inputs to the model.
  task automatic model_edge();
    if (wen && waddr != 5'd0) m_rf[waddr] = wdata;
    if (flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      if (wen && waddr != 5'd0) m_busy[waddr] = 1'b0;
      if (issue_en && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wen && waddr == a) return wdata;
    return m_rf[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    return m_busy[a] && !(wen && waddr == a);
  endfunction

  function automatic logic exp_any();
    logic r;
    r = 1'b0;
    for (int i = 0; i < 32; i++) r = r | m_busy[i];
    return r;
  endfunction

  // One clock edge; inputs are re-driven 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    raddr = 10'd0; issue_en = 1'b0; issue_rd = 5'd0; wen = 1'b0;
    waddr = 5'd0; wdata = 32'd0; flush = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    wen = 1'b1; waddr = 5'd5; wdata = 32'h1234;
    issue_en = 1'b1; issue_rd = 5'd6;
    tick();
    idle();
    raddr = {5'd6, 5'd5};
    #2;
    nvec++;
    if (rdata[31:0] !== 32'h1234) begin
      nerr++; $display("FAIL pre_reset_x5: got %h expected %h", rdata[31:0], 32'h1234);
    end
    nvec++;
    if (rbusy[1] !== 1'b1 || any_busy !== 1'b1) begin
      nerr++; $display("FAIL pre_reset_busy: got rbusy1=%b any=%b expected 1 1", rbusy[1], any_busy);
    end
    rst_n = 1'b0;
    #1;
    nvec++;
    if (rdata !== 64'd0) begin
      nerr++; $display("FAIL reset_rdata: got %h expected 0", rdata);
    end
    nvec++;
    if (rbusy !== 2'b00 || any_busy !== 1'b0) begin
      nerr++; $display("FAIL reset_busy: got rbusy=%b any=%b expected 00 0", rbusy, any_busy);
    end
    model_reset();
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    idle();
    wen = 1'b1; waddr = 5'd3; wdata = 32'hDEADBEEF;
    tick();
    idle();
    raddr = {5'd0, 5'd3};
    #2;
    nvec++;
    if (rdata[31:0] !== 32'hDEADBEEF || rdata[63:32] !== 32'd0) begin
      nerr++; $display("FAIL write_read: got %h expected %h", rdata, 64'h00000000DEADBEEF);
    end
    wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFF;
    raddr = {5'd0, 5'd0};
    #2;
    nvec++;
    if (rdata !== 64'd0) begin
      nerr++; $display("FAIL x0_bypass: got %h expected 0", rdata);
    end
    tick();
    idle();
    #2;
    nvec++;
    if (rdata !== 64'd0) begin
      nerr++; $display("FAIL x0_write: got %h expected 0", rdata);
    end
  endtask

  task automatic test_issue_bypass();
    idle();
    issue_en = 1'b1; issue_rd = 5'd7;
    tick();
    idle();
    raddr = {5'd0, 5'd7};
    for (int c = 0; c < 2; c++) begin
      #2;
      nvec++;
      if (rbusy[0] !== 1'b1 || any_busy !== 1'b1) begin
        nerr++; $display("FAIL issue_busy_c%0d: got rbusy0=%b any=%b expected 1 1", c, rbusy[0], any_busy);
      end
      tick();
    end
    wen = 1'b1; waddr = 5'd7; wdata = 32'h55;
    #2;
    nvec++;
    if (rdata[31:0] !== 32'h55 || rbusy[0] !== 1'b0) begin
      nerr++; $display("FAIL wb_bypass: got %h busy=%b expected 55 0", rdata[31:0], rbusy[0]);
    end
    tick();
    wen = 1'b0;
    #2;
    nvec++;
    if (rdata[31:0] !== 32'h55 || rbusy[0] !== 1'b0 || any_busy !== 1'b0) begin
      nerr++; $display("FAIL wb_array: got %h busy=%b any=%b expected 55 0 0", rdata[31:0], rbusy[0], any_busy);
    end
  endtask

  task automatic test_issue_wb_same();
    idle();
    issue_en = 1'b1; issue_rd = 5'd9;
    wen = 1'b1; waddr = 5'd9; wdata = 32'hA;
    tick();
    idle();
    raddr = {5'd0, 5'd9};
    #2;
    nvec++;
    if (rdata[31:0] !== 32'hA || rbusy[0] !== 1'b1 || any_busy !== 1'b1) begin
      nerr++; $display("FAIL issue_wins: got %h busy=%b any=%b expected a 1 1", rdata[31:0], rbusy[0], any_busy);
    end
    wen = 1'b1; waddr = 5'd9; wdata = 32'hA;
    tick();
    idle();
  endtask

  task automatic test_flush();
    idle();
    issue_en = 1'b1;
    issue_rd = 5'd1; tick();
    issue_rd = 5'd2; tick();
    issue_rd = 5'd4; tick();
    flush = 1'b1; issue_rd = 5'd8;
    wen = 1'b1; waddr = 5'd2; wdata = 32'h77;
    tick();
    idle();
    raddr = {5'd2, 5'd8};
    #2;
    nvec++;
    if (any_busy !== 1'b0 || rbusy !== 2'b00) begin
      nerr++; $display("FAIL flush_busy: got any=%b rbusy=%b expected 0 00", any_busy, rbusy);
    end
    nvec++;
    if (rdata[63:32] !== 32'h77) begin
      nerr++; $display("FAIL flush_write: got %h expected 77", rdata[63:32]);
    end
    raddr = {5'd4, 5'd1};
    #1;
    nvec++;
    if (rbusy !== 2'b00) begin
      nerr++; $display("FAIL flush_others: got %b expected 00", rbusy);
    end
  endtask

  task automatic test_random();
    logic [4:0] a;
    for (int c = 0; c < 400; c++) begin
      wen      = 1'($urandom_range(0, 1));
      waddr    = 5'($urandom_range(0, 7));
      wdata    = $urandom;
      issue_rd = 5'($urandom_range(0, 7));
      issue_en = ($urandom_range(0, 1) == 1) && !m_busy[issue_rd];
      flush    = ($urandom_range(0, 24) == 0);
      raddr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      #2;
      for (int k = 0; k < 2; k++) begin
        a = raddr[k*5 +: 5];
        nvec++;
        if (rdata[k*32 +: 32] !== exp_data(a) || rbusy[k] !== exp_busy(a)) begin
          nerr++;
          $display("FAIL rand_port%0d cyc%0d x%0d: got %h/%b expected %h/%b",
                   k, c, a, rdata[k*32 +: 32], rbusy[k], exp_data(a), exp_busy(a));
        end
      end
      nvec++;
      if (any_busy !== exp_any()) begin
        nerr++; $display("FAIL rand_any cyc%0d: got %b expected %b", c, any_busy, exp_any());
      end
      tick();
    end
    idle();
  endtask

  task automatic test_wide();
    w_wen = 1'b1; w_waddr = 4'd15; w_wdata = 16'hBEEF;
    w_raddr = {4'd15, 4'd15, 4'd15, 4'd15};
    w_issue_en = 1'b1; w_issue_rd = 4'd0;
    #2;
    for (int k = 0; k < 4; k++) begin
      nvec++;
      if (w_rdata[k*16 +: 16] !== 16'hBEEF || w_rbusy[k] !== 1'b0) begin
        nerr++; $display("FAIL wide_bypass_p%0d: got %h/%b expected beef/0", k, w_rdata[k*16 +: 16], w_rbusy[k]);
      end
    end
    tick();
    w_wen = 1'b0; w_issue_en = 1'b0;
    #2;
    nvec++;
    if (w_any_busy !== 1'b0) begin
      nerr++; $display("FAIL wide_issue_x0: got any=%b expected 0", w_any_busy);
    end
    nvec++;
    if (w_rdata[63:48] !== 16'hBEEF) begin
      nerr++; $display("FAIL wide_array: got %h expected beef", w_rdata[63:48]);
    end
  endtask

  initial begin
    nvec = 0; nerr = 0;
    rst_n = 1'b0;
    idle();
    w_raddr = 16'd0; w_issue_en = 1'b0; w_issue_rd = 4'd0; w_wen = 1'b0;
    w_waddr = 4'd0; w_wdata = 16'd0; w_flush = 1'b0;
    model_reset();
    #12;
    rst_n = 1'b1;
    tick();
    test_reset();
    test_write_read();
    test_issue_bypass();
    test_issue_wb_same();
    test_flush();
    test_random();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
